// File: rtl/multicycle_sequencer_if.sv
// Shared memory request/acknowledge bundle between the sequencer and memory.
// master: sequencer drives the requests; slave: memory returns mem_ack.
interface multicycle_sequencer_if;
    logic imem_req;
    logic dmem_req;
    logic dmem_we;
    logic mem_ack;

    modport master (
        output imem_req,
        output dmem_req,
        output dmem_we,
        input  mem_ack
    );

    modport slave (
        input  imem_req,
        input  dmem_req,
        input  dmem_we,
        output mem_ack
    );
endinterface

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM: FETCH/DECODE/EXEC/MEM/WB with sticky FAULT.
// Ports: clk, reset, mem (request/ack bundle), decoder flags, alu_zero,
//        IR/RF/PC strobes, fault, state, instret (retired count).
module multicycle_sequencer #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    multicycle_sequencer_if.master mem,
    input  logic             dec_mem_read,
    input  logic             dec_mem_write,
    input  logic             dec_reg_write,
    input  logic             dec_branch,
    input  logic             alu_zero,
    output logic             ir_write,
    output logic             rf_we,
    output logic             pc_write,
    output logic             pc_src,
    output logic             fault,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instret
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_FAULT  = 3'd7;

    // Counter only ever holds 0..TIMEOUT-1 before the state is left.
    localparam int WCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WCW-1:0] LIM =
        (TIMEOUT > 0) ? WCW'(TIMEOUT - 1) : '0;
    localparam bit TO_EN = (TIMEOUT != 0);

    logic [2:0]     st, nxt;
    logic [WCW-1:0] wait_cnt;
    logic           timed_out;
    logic           retire;
    logic           waiting;

    assign timed_out = TO_EN && (wait_cnt == LIM);
    assign waiting   = (st == S_FETCH || st == S_MEM) && !mem.mem_ack;

    always_comb begin
        nxt          = st;
        mem.imem_req = 1'b0;
        mem.dmem_req = 1'b0;
        mem.dmem_we  = 1'b0;
        ir_write     = 1'b0;
        rf_we        = 1'b0;
        pc_write     = 1'b0;
        pc_src       = 1'b0;
        retire       = 1'b0;
        case (st)
            S_FETCH: begin
                mem.imem_req = 1'b1;
                if (mem.mem_ack) begin
                    ir_write = 1'b1;
                    nxt      = S_DECODE;
                end else if (timed_out) begin
                    nxt = S_FAULT;
                end
            end
            S_DECODE: nxt = S_EXEC;
            S_EXEC: begin
                if (dec_mem_read && dec_mem_write) begin
                    nxt = S_FAULT;
                end else if (dec_branch) begin
                    pc_write = 1'b1;
                    pc_src   = alu_zero;
                    retire   = 1'b1;
                    nxt      = S_FETCH;
                end else if (dec_mem_read || dec_mem_write) begin
                    nxt = S_MEM;
                end else if (dec_reg_write) begin
                    nxt = S_WB;
                end else begin
                    // Unsupported opcode retires as a NOP.
                    pc_write = 1'b1;
                    retire   = 1'b1;
                    nxt      = S_FETCH;
                end
            end
            S_MEM: begin
                mem.dmem_req = 1'b1;
                mem.dmem_we  = dec_mem_write;
                if (mem.mem_ack) begin
                    if (dec_mem_write) begin
                        pc_write = 1'b1;
                        retire   = 1'b1;
                        nxt      = S_FETCH;
                    end else begin
                        nxt = S_WB;
                    end
                end else if (timed_out) begin
                    nxt = S_FAULT;
                end
            end
            S_WB: begin
                rf_we    = 1'b1;
                pc_write = 1'b1;
                retire   = 1'b1;
                nxt      = S_FETCH;
            end
            S_FAULT: nxt = S_FAULT;
            // Encodings 5 and 6 are unreachable; park them safely.
            default: nxt = S_FAULT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st       <= S_FETCH;
            wait_cnt <= '0;
            instret  <= '0;
        end else begin
            st <= nxt;
            if (nxt != st) begin
                wait_cnt <= '0;
            end else if (waiting) begin
                wait_cnt <= wait_cnt + WCW'(1);
            end
            if (retire) begin
                instret <= instret + CNT_W'(1);
            end
        end
    end

    assign state = st;
    assign fault = (st == S_FAULT);

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scoreboard bench: driver queues per-cycle expectations, monitor checks.
// Two instances: TIMEOUT=4/CNT_W=32 and TIMEOUT=0/CNT_W=2 (wrap test).
module tb_multicycle_sequencer;

    typedef struct {
        string      name;
        logic [2:0] st;
        logic [7:0] sb;
        logic [31:0] ir;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // flags = {mem_read, mem_write, reg_write, branch, alu_zero}
    localparam logic [4:0] F_NOP  = 5'b00000;
    localparam logic [4:0] F_ADDI = 5'b00100;
    localparam logic [4:0] F_LD   = 5'b10100;
    localparam logic [4:0] F_ST   = 5'b01000;
    localparam logic [4:0] F_BZ   = 5'b00011;
    localparam logic [4:0] F_BNZ  = 5'b00010;
    localparam logic [4:0] F_BAD  = 5'b11000;

    // strobes = {imem_req, ir_write, dmem_req, dmem_we,
    //            rf_we, pc_write, pc_src, fault}
    localparam logic [7:0] SB_F   = 8'b1000_0000;
    localparam logic [7:0] SB_FA  = 8'b1100_0000;
    localparam logic [7:0] SB_0   = 8'b0000_0000;
    localparam logic [7:0] SB_WB  = 8'b0000_1100;
    localparam logic [7:0] SB_MR  = 8'b0010_0000;
    localparam logic [7:0] SB_ST  = 8'b0011_0100;
    localparam logic [7:0] SB_BT  = 8'b0000_0110;
    localparam logic [7:0] SB_BN  = 8'b0000_0100;
    localparam logic [7:0] SB_FLT = 8'b0000_0001;

    // DUT0
    logic rst0 = 1'b1;
    logic [4:0] fl0 = '0;
    logic irw0, rfw0, pcw0, pcs0, flt0;
    logic [2:0] st0;
    logic [31:0] ir0;
    multicycle_sequencer_if if0 ();

    multicycle_sequencer #(.TIMEOUT(4), .CNT_W(32)) u_dut0 (
        .clk(clk), .reset(rst0), .mem(if0.master),
        .dec_mem_read(fl0[4]), .dec_mem_write(fl0[3]),
        .dec_reg_write(fl0[2]), .dec_branch(fl0[1]),
        .alu_zero(fl0[0]),
        .ir_write(irw0), .rf_we(rfw0), .pc_write(pcw0),
        .pc_src(pcs0), .fault(flt0), .state(st0), .instret(ir0)
    );

    // DUT1
    logic rst1 = 1'b1;
    logic [4:0] fl1 = '0;
    logic irw1, rfw1, pcw1, pcs1, flt1;
    logic [2:0] st1;
    logic [1:0] ir1;
    multicycle_sequencer_if if1 ();

    multicycle_sequencer #(.TIMEOUT(0), .CNT_W(2)) u_dut1 (
        .clk(clk), .reset(rst1), .mem(if1.master),
        .dec_mem_read(fl1[4]), .dec_mem_write(fl1[3]),
        .dec_reg_write(fl1[2]), .dec_branch(fl1[1]),
        .alu_zero(fl1[0]),
        .ir_write(irw1), .rf_we(rfw1), .pc_write(pcw1),
        .pc_src(pcs1), .fault(flt1), .state(st1), .instret(ir1)
    );

    initial begin
        if0.mem_ack = 1'b0;
        if1.mem_ack = 1'b0;
    end

    wire [7:0] sb0 = {if0.imem_req, irw0, if0.dmem_req, if0.dmem_we,
                      rfw0, pcw0, pcs0, flt0};
    wire [7:0] sb1 = {if1.imem_req, irw1, if1.dmem_req, if1.dmem_we,
                      rfw1, pcw1, pcs1, flt1};

    task automatic check(input exp_t e, input logic [2:0] st,
                         input logic [7:0] sb, input logic [31:0] ir);
        n_chk++;
        if (st !== e.st || sb !== e.sb || ir !== e.ir) begin
            n_fail++;
            $display("FAIL %s: got st=%0d sb=%b ir=%0d, want st=%0d sb=%b ir=%0d",
                     e.name, st, sb, ir, e.st, e.sb, e.ir);
        end
    endtask

    // Monitor: compares whatever the DUTs present on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            check(e, st0, sb0, ir0);
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            check(e, st1, sb1, {30'd0, ir1});
        end
    end

    task automatic step(input int d, input string nm, input logic rs,
                        input logic [4:0] f, input logic ack,
                        input logic [2:0] st, input logic [7:0] sb,
                        input logic [31:0] ir);
        exp_t e;
        e.name = nm;
        e.st   = st;
        e.sb   = sb;
        e.ir   = ir;
        if (d == 0) begin
            rst0 = rs; fl0 = f; if0.mem_ack = ack;
            q0.push_back(e);
        end else begin
            rst1 = rs; fl1 = f; if1.mem_ack = ack;
            q1.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst0 = 1'b0;

        // ALU op, ack tied high
        step(0, "addi_fetch",  0, F_ADDI, 1, 3'd0, SB_FA, 0);
        step(0, "addi_dec",    0, F_ADDI, 1, 3'd1, SB_0,  0);
        step(0, "addi_exec",   0, F_ADDI, 1, 3'd2, SB_0,  0);
        step(0, "addi_wb",     0, F_ADDI, 1, 3'd4, SB_WB, 0);

        // Load, ack on 4th MEM cycle (timeout boundary)
        step(0, "ld_fetch",    0, F_LD, 1, 3'd0, SB_FA, 1);
        step(0, "ld_dec",      0, F_LD, 1, 3'd1, SB_0,  1);
        step(0, "ld_exec",     0, F_LD, 1, 3'd2, SB_0,  1);
        step(0, "ld_mem0",     0, F_LD, 0, 3'd3, SB_MR, 1);
        step(0, "ld_mem1",     0, F_LD, 0, 3'd3, SB_MR, 1);
        step(0, "ld_mem2",     0, F_LD, 0, 3'd3, SB_MR, 1);
        step(0, "ld_mem3",     0, F_LD, 1, 3'd3, SB_MR, 1);
        step(0, "ld_wb",       0, F_LD, 1, 3'd4, SB_WB, 1);

        // Branch taken then not taken
        step(0, "bz_fetch",    0, F_BZ, 1, 3'd0, SB_FA, 2);
        step(0, "bz_dec",      0, F_BZ, 1, 3'd1, SB_0,  2);
        step(0, "bz_exec",     0, F_BZ, 1, 3'd2, SB_BT, 2);
        step(0, "bnz_fetch",   0, F_BNZ, 1, 3'd0, SB_FA, 3);
        step(0, "bnz_dec",     0, F_BNZ, 1, 3'd1, SB_0,  3);
        step(0, "bnz_exec",    0, F_BNZ, 1, 3'd2, SB_BN, 3);

        // Store and NOP
        step(0, "st_fetch",    0, F_ST, 1, 3'd0, SB_FA, 4);
        step(0, "st_dec",      0, F_ST, 1, 3'd1, SB_0,  4);
        step(0, "st_exec",     0, F_ST, 1, 3'd2, SB_0,  4);
        step(0, "st_mem",      0, F_ST, 1, 3'd3, SB_ST, 4);
        step(0, "nop_fetch",   0, F_NOP, 1, 3'd0, SB_FA, 5);
        step(0, "nop_dec",     0, F_NOP, 1, 3'd1, SB_0,  5);
        step(0, "nop_exec",    0, F_NOP, 1, 3'd2, SB_BN, 5);

        // Illegal load+store: FAULT, no data request
        step(0, "bad_fetch",   0, F_BAD, 1, 3'd0, SB_FA, 6);
        step(0, "bad_dec",     0, F_BAD, 1, 3'd1, SB_0,  6);
        step(0, "bad_exec",    0, F_BAD, 1, 3'd2, SB_0,  6);
        step(0, "bad_fault0",  0, F_BAD, 1, 3'd7, SB_FLT, 6);
        step(0, "bad_fault1",  0, F_BAD, 1, 3'd7, SB_FLT, 6);
        step(0, "bad_rst",     1, F_NOP, 0, 3'd7, SB_FLT, 6);
        step(0, "bad_post",    0, F_NOP, 0, 3'd0, SB_F,  0);

        // Fetch timeout: fault after 4 unacked cycles
        step(0, "to_f1",       0, F_NOP, 0, 3'd0, SB_F,  0);
        step(0, "to_f2",       0, F_NOP, 0, 3'd0, SB_F,  0);
        step(0, "to_f3",       0, F_NOP, 0, 3'd0, SB_F,  0);
        step(0, "to_fault",    0, F_NOP, 1, 3'd7, SB_FLT, 0);
        step(0, "to_rst",      1, F_NOP, 0, 3'd7, SB_FLT, 0);
        step(0, "to_post",     0, F_NOP, 0, 3'd0, SB_F,  0);

        // DUT1: no timeout, 2-bit counter wraps
        rst1 = 1'b0;
        for (int i = 0; i < 20; i++)
            step(1, "inf_wait", 0, F_NOP, 0, 3'd0, SB_F, 0);
        for (int n = 0; n < 4; n++) begin
            step(1, "wrap_fetch", 0, F_NOP, 1, 3'd0, SB_FA, 32'(n));
            step(1, "wrap_dec",   0, F_NOP, 1, 3'd1, SB_0,  32'(n));
            step(1, "wrap_exec",  0, F_NOP, 1, 3'd2, SB_BN, 32'(n));
        end
        step(1, "wrap_zero",   0, F_NOP, 0, 3'd0, SB_F, 0);

        @(negedge clk);
        #1;
        if (q0.size() != 0 || q1.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: got %0d/%0d pending, want 0/0",
                     q0.size(), q1.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
